// File: rtl/prog_mem_ctrl.sv
// prog_mem_ctrl: writable program memory for the PIC-style core.
//   - Registered fetch port, one-cycle latency, out-of-range fetches return FILL_WORD.
//   - Streaming loader writes words from address 0 upward while in LOAD.
//   - After reset the array is swept to FILL_WORD (CLEAR); fetches are blocked
//     during CLEAR and LOAD.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   fetch_req_in/addr_in    : fetch request and address (accepted only when fetch_ready_out)
//   fetch_data_out/valid_out: fetched word, valid one cycle after acceptance
//   fetch_ready_out         : high in IDLE
//   load_start_in           : IDLE -> start load at 0; LOAD -> end load early
//   load_word_in/valid_in   : word stream to write
//   load_ready_out          : high in LOAD
//   load_count_out          : words written in the current/last load
//   load_busy_out           : high in CLEAR or LOAD
//   load_done_out           : one-cycle pulse when a load ends
//   load_err_out            : sticky, set by load_valid_in in IDLE without load_start_in
module prog_mem_ctrl #(
  parameter int unsigned       DATA_W    = 14,
  parameter int unsigned       ADDR_W    = 11,
  parameter int unsigned       DEPTH     = 2048,
  parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req_in,
  input  logic [ADDR_W-1:0] fetch_addr_in,
  output logic [DATA_W-1:0] fetch_data_out,
  output logic              fetch_valid_out,
  output logic              fetch_ready_out,
  input  logic              load_start_in,
  input  logic [DATA_W-1:0] load_word_in,
  input  logic              load_valid_in,
  output logic              load_ready_out,
  output logic [ADDR_W:0]   load_count_out,
  output logic              load_busy_out,
  output logic              load_done_out,
  output logic              load_err_out
);

  localparam int unsigned   IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_LOAD} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clr_ptr;
  logic              clear_last, load_end, fetch_acc, fetch_in_range;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr, mem_raddr;
  logic [DATA_W-1:0] mem_wdata;

  // Event decode shared by the FSM and datapath
  always_comb begin
    clear_last     = (state == ST_CLEAR) && ({1'b0, clr_ptr} == LAST);
    load_end       = (state == ST_LOAD) &&
                     (load_start_in || (load_valid_in && (load_count_out == LAST)));
    fetch_acc      = (state == ST_IDLE) && fetch_req_in;
    fetch_in_range = ({1'b0, fetch_addr_in} < DEPTH_L);
    mem_raddr      = fetch_addr_in[IDX_W-1:0];
  end

  // Single write port: clear sweep or loader. The load count doubles as the
  // write pointer. Writes are suppressed while rst is high so an aborted
  // load cannot land one more word.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_ptr[IDX_W-1:0];
    mem_wdata = FILL_WORD;
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem_we = 1'b1;
      end else if (state == ST_LOAD && load_valid_in) begin
        mem_we    = 1'b1;
        mem_waddr = load_count_out[IDX_W-1:0];
        mem_wdata = load_word_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clear_last)    state_nxt = ST_IDLE;
      ST_IDLE:  if (load_start_in) state_nxt = ST_LOAD;
      ST_LOAD:  if (load_end)      state_nxt = ST_IDLE;
      default:                     state_nxt = ST_CLEAR;
    endcase
  end

  // FSM: state-decoded outputs
  always_comb begin
    fetch_ready_out = (state == ST_IDLE);
    load_ready_out  = (state == ST_LOAD);
    load_busy_out   = (state == ST_CLEAR) || (state == ST_LOAD);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ptr         <= '0;
      load_count_out  <= '0;
      fetch_data_out  <= FILL_WORD;
      fetch_valid_out <= 1'b0;
      load_done_out   <= 1'b0;
      load_err_out    <= 1'b0;
    end else begin
      fetch_valid_out <= fetch_acc;
      load_done_out   <= load_end;
      if (fetch_acc)
        fetch_data_out <= fetch_in_range ? mem[mem_raddr] : FILL_WORD;
      case (state)
        ST_CLEAR: clr_ptr <= clr_ptr + 1'b1;
        ST_IDLE: begin
          if (load_start_in) begin
            load_count_out <= '0;
            load_err_out   <= 1'b0;
          end else if (load_valid_in) begin
            load_err_out   <= 1'b1;
          end
        end
        ST_LOAD: if (load_valid_in) load_count_out <= load_count_out + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_ctrl.sv
module tb_prog_mem_ctrl;
  localparam int DW = 14;
  localparam int AW = 11;
  localparam int DP = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic [DW-1:0] fetch_data;
  logic          fetch_valid, fetch_ready;
  logic          load_start = 1'b0;
  logic [DW-1:0] load_word = '0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [AW:0]   load_count;
  logic          load_busy, load_done, load_err;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] w1 [25];
  logic [DW-1:0] v2 [32];

  prog_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .FILL_WORD(14'h0000)) dut (
    .clk(clk), .rst(rst),
    .fetch_req_in(fetch_req), .fetch_addr_in(fetch_addr),
    .fetch_data_out(fetch_data), .fetch_valid_out(fetch_valid), .fetch_ready_out(fetch_ready),
    .load_start_in(load_start), .load_word_in(load_word), .load_valid_in(load_valid),
    .load_ready_out(load_ready), .load_count_out(load_count), .load_busy_out(load_busy),
    .load_done_out(load_done), .load_err_out(load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v);
    fetch_req = 1'b1; fetch_addr = a;
    step();
    d = fetch_data; v = fetch_valid;
    fetch_req = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    step(); step();
    total++;
    if ({load_busy, fetch_ready, load_ready, fetch_valid, load_done, load_err} !== 6'b100000) begin
      bad++; $display("FAIL reset_flags got %b exp 100000",
        {load_busy, fetch_ready, load_ready, fetch_valid, load_done, load_err});
    end
    total++;
    if ({load_count, fetch_data} !== {12'd0, 14'h0000}) begin
      bad++; $display("FAIL reset_count_data got %0h/%0h exp 0/0", load_count, fetch_data);
    end
    rst = 1'b0;
    n = 0;
    while (load_busy === 1'b1 && n < 100) begin n++; step(); end
    total++;
    if (n !== 32) begin bad++; $display("FAIL clear_cycles got %0d exp 32", n); end
    total++;
    if (fetch_ready !== 1'b1) begin bad++; $display("FAIL ready_after_clear got %b exp 1", fetch_ready); end
  endtask

  task automatic test_fetch_all_fill;
    fetch_req = 1'b1;
    for (int a = 0; a < DP; a++) begin
      fetch_addr = 11'(a);
      step();
      total++;
      if ({fetch_valid, fetch_data} !== {1'b1, 14'h0000}) begin
        bad++; $display("FAIL fill_fetch[%0d] got v=%b d=%0h exp v=1 d=0", a, fetch_valid, fetch_data);
      end
    end
    fetch_req = 1'b0;
    step();
    total++;
    if (fetch_valid !== 1'b0) begin bad++; $display("FAIL fetch_idle_valid got %b exp 0", fetch_valid); end
  endtask

  task automatic test_load_early;
    logic [DW-1:0] d; logic v;
    load_start = 1'b1; step(); load_start = 1'b0;
    total++;
    if ({load_ready, load_busy, fetch_ready, load_count} !== {3'b110, 12'd0}) begin
      bad++; $display("FAIL load_enter got r/b/f=%b cnt=%0d exp 110 cnt=0",
        {load_ready, load_busy, fetch_ready}, load_count);
    end
    for (int i = 0; i < 25; i++) begin
      load_valid = 1'b1; load_word = w1[i]; load_start = (i == 24);
      step();
      if (i < 24) begin
        total++;
        if (load_done !== 1'b0) begin bad++; $display("FAIL early_done[%0d] got %b exp 0", i, load_done); end
      end
    end
    load_valid = 1'b0; load_start = 1'b0;
    total++;
    if ({load_done, load_ready, load_count} !== {2'b10, 12'd25}) begin
      bad++; $display("FAIL early_end got done=%b ready=%b cnt=%0d exp 1 0 25", load_done, load_ready, load_count);
    end
    step();
    total++;
    if ({load_done, load_count} !== {1'b0, 12'd25}) begin
      bad++; $display("FAIL early_pulse got done=%b cnt=%0d exp 0 25", load_done, load_count);
    end
    do_fetch(11'h003, d, v);
    total++;
    if ({v, d} !== {1'b1, 14'h3024}) begin bad++; $display("FAIL fetch_03 got v=%b d=%0h exp 1 3024", v, d); end
    do_fetch(11'h018, d, v);
    total++;
    if ({v, d} !== {1'b1, 14'h3400}) begin bad++; $display("FAIL fetch_18 got v=%b d=%0h exp 1 3400", v, d); end
    do_fetch(11'h019, d, v);
    total++;
    if ({v, d} !== {1'b1, 14'h0000}) begin bad++; $display("FAIL fetch_19 got v=%b d=%0h exp 1 0", v, d); end
  endtask

  task automatic test_start_with_fetch;
    load_start = 1'b1; fetch_req = 1'b1; fetch_addr = 11'h003;
    step();
    load_start = 1'b0;
    total++;
    if ({fetch_valid, fetch_data, load_ready} !== {1'b1, 14'h3024, 1'b1}) begin
      bad++; $display("FAIL start_fetch got v=%b d=%0h lr=%b exp 1 3024 1", fetch_valid, fetch_data, load_ready);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if ({fetch_valid, fetch_data} !== {1'b0, 14'h3024}) begin
        bad++; $display("FAIL fetch_in_load[%0d] got v=%b d=%0h exp 0 3024", k, fetch_valid, fetch_data);
      end
    end
    fetch_req = 1'b0; load_start = 1'b1;
    step();
    load_start = 1'b0;
    total++;
    if ({load_done, load_ready, load_count} !== {2'b10, 12'd0}) begin
      bad++; $display("FAIL empty_load_end got done=%b lr=%b cnt=%0d exp 1 0 0", load_done, load_ready, load_count);
    end
  endtask

  task automatic test_load_gapped;
    logic [DW-1:0] d; logic v;
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      load_valid = 1'b1; load_word = v2[i];
      step();
      load_valid = 1'b0;
      if (i < 31) begin
        total++;
        if ({load_ready, load_done} !== 2'b10) begin
          bad++; $display("FAIL gapped_mid[%0d] got lr/done=%b exp 10", i, {load_ready, load_done});
        end
        step();
      end
    end
    total++;
    if ({load_ready, load_done, load_count} !== {2'b01, 12'd32}) begin
      bad++; $display("FAIL gapped_end got lr=%b done=%b cnt=%0d exp 0 1 32", load_ready, load_done, load_count);
    end
    load_valid = 1'b1; load_word = 14'h3FFF;
    step();
    load_valid = 1'b0;
    total++;
    if ({load_err, load_ready} !== 2'b10) begin
      bad++; $display("FAIL stray_valid got err=%b lr=%b exp 1 0", load_err, load_ready);
    end
    do_fetch(11'h000, d, v);
    total++;
    if ({v, d} !== {1'b1, v2[0]}) begin bad++; $display("FAIL gapped_fetch0 got v=%b d=%0h exp 1 %0h", v, d, v2[0]); end
    do_fetch(11'h003, d, v);
    total++;
    if ({v, d} !== {1'b1, v2[3]}) begin bad++; $display("FAIL gapped_fetch3 got v=%b d=%0h exp 1 %0h", v, d, v2[3]); end
  endtask

  task automatic test_fetch_oob;
    logic [DW-1:0] d; logic v;
    do_fetch(11'h01F, d, v);
    total++;
    if ({v, d} !== {1'b1, v2[31]}) begin bad++; $display("FAIL fetch_1f got v=%b d=%0h exp 1 %0h", v, d, v2[31]); end
    do_fetch(11'h7FF, d, v);
    total++;
    if ({v, d} !== {1'b1, 14'h0000}) begin bad++; $display("FAIL fetch_7ff got v=%b d=%0h exp 1 0", v, d); end
    do_fetch(11'h005, d, v);
    total++;
    if ({v, d} !== {1'b1, v2[5]}) begin bad++; $display("FAIL fetch_05 got v=%b d=%0h exp 1 %0h", v, d, v2[5]); end
    do_fetch(11'h020, d, v);
    total++;
    if ({v, d} !== {1'b1, 14'h0000}) begin bad++; $display("FAIL fetch_020 got v=%b d=%0h exp 1 0", v, d); end
  endtask

  task automatic test_reset_mid_load;
    int n;
    logic seen_done;
    load_start = 1'b1; step(); load_start = 1'b0;
    total++;
    if ({load_err, load_ready} !== 2'b01) begin
      bad++; $display("FAIL err_clear_on_start got err=%b lr=%b exp 0 1", load_err, load_ready);
    end
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1; load_word = 14'h3A00 + 14'(i);
      step();
    end
    load_word = 14'h3AFF;
    rst = 1'b1;
    step();
    total++;
    if ({load_done, load_busy, load_count} !== {2'b01, 12'd0}) begin
      bad++; $display("FAIL rst_abort got done=%b busy=%b cnt=%0d exp 0 1 0", load_done, load_busy, load_count);
    end
    step();
    rst = 1'b0; load_valid = 1'b0;
    n = 0; seen_done = 1'b0;
    while (load_busy === 1'b1 && n < 100) begin
      n++; step();
      seen_done = seen_done | load_done;
    end
    total++;
    if (n !== 32) begin bad++; $display("FAIL reclear_cycles got %0d exp 32", n); end
    total++;
    if (seen_done !== 1'b0) begin bad++; $display("FAIL reclear_done got %b exp 0", seen_done); end
    test_fetch_all_fill();
  endtask

  initial begin
    for (int i = 0; i < 25; i++) w1[i] = 14'h1000 + 14'(i);
    w1[0] = 14'h01A5; w1[1] = 14'h01A4; w1[2] = 14'h01A3; w1[3] = 14'h3024; w1[24] = 14'h3400;
    for (int i = 0; i < 32; i++) v2[i] = 14'h2000 + 14'(i * 5);

    test_reset();
    test_fetch_all_fill();
    test_load_early();
    test_start_with_fetch();
    test_load_gapped();
    test_fetch_oob();
    test_reset_mid_load();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
